// File: rtl/sram_mbist_pkg.sv
// rtl/sram_mbist_pkg.sv - March C- element table, backgrounds and FSM state type for sram_mbist
package sram_mbist_pkg;

    localparam int         NUM_ELEM = 6;
    localparam logic [7:0] BG0      = 8'h00;
    localparam logic [7:0] BG1      = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // op_cnt is 1 or 2; with two ops the read always precedes the write
    typedef struct packed {
        logic       down;
        logic [1:0] op_cnt;
        logic       rd_first;
        logic [7:0] rd_bg;
        logic [7:0] wr_bg;
    } elem_t;

    function automatic logic elem_is_down(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    function automatic elem_t elem_info(input logic [2:0] e);
        elem_t t;
        t.down = elem_is_down(e);
        case (e)
            3'd0:    begin t.op_cnt = 2'd1; t.rd_first = 1'b0; t.rd_bg = BG0; t.wr_bg = BG0; end
            3'd1:    begin t.op_cnt = 2'd2; t.rd_first = 1'b1; t.rd_bg = BG0; t.wr_bg = BG1; end
            3'd2:    begin t.op_cnt = 2'd2; t.rd_first = 1'b1; t.rd_bg = BG1; t.wr_bg = BG0; end
            3'd3:    begin t.op_cnt = 2'd2; t.rd_first = 1'b1; t.rd_bg = BG0; t.wr_bg = BG1; end
            3'd4:    begin t.op_cnt = 2'd2; t.rd_first = 1'b1; t.rd_bg = BG1; t.wr_bg = BG0; end
            default: begin t.op_cnt = 2'd1; t.rd_first = 1'b1; t.rd_bg = BG0; t.wr_bg = BG0; end
        endcase
        return t;
    endfunction

endpackage

// File: rtl/sram_mbist_addr_gen.sv
// rtl/sram_mbist_addr_gen.sv - up/down March address counter with load and terminal-count flag
module sram_mbist_addr_gen #(
    parameter int DEPTH  = 1536,
    parameter int ADDR_W = 11
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              down_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              tc_o
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              down_q;

    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d = down_i ? LAST : '0;
        end else if (step_i) begin
            addr_d = down_q ? addr_q - 1'b1 : addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q <= '0;
            down_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            if (load_i) begin
                down_q <= down_i;
            end
        end
    end

    // Terminal count is DEPTH-1 going up, so the unpopulated top of the address space is never issued
    assign tc_o   = down_q ? (addr_q == '0) : (addr_q == LAST);
    assign addr_o = addr_q;

endmodule

// File: rtl/sram_mbist.sv
// rtl/sram_mbist.sv - March C- BIST controller with functional bypass mux for the 1536x8 SRAM macro
module sram_mbist
    import sram_mbist_pkg::*;
#(
    parameter int DEPTH  = 1536,
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              start,
    input  logic              func_csb,
    input  logic              func_web,
    input  logic              func_oeb,
    input  logic [ADDR_W-1:0] func_a,
    input  logic [DATA_W-1:0] func_di,
    output logic              mem_csb,
    output logic              mem_web,
    output logic              mem_oeb,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_di,
    input  logic [DATA_W-1:0] mem_do,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem
);

    state_e            state_q;
    logic [2:0]        elem_q;
    logic              phase_q;
    logic              busy_q, done_q, fail_q;
    logic [ADDR_W-1:0] fail_addr_q;
    logic [2:0]        fail_elem_q;
    logic              cmp_vld_q;
    logic [DATA_W-1:0] cmp_exp_q;
    logic [ADDR_W-1:0] cmp_addr_q;
    logic [2:0]        cmp_elem_q;

    elem_t             cur;
    logic [ADDR_W-1:0] addr;
    logic              tc, is_rd, last_op, run_op, start_ok, mismatch;
    logic              ag_load, ag_down, ag_step;

    assign cur      = elem_info(elem_q);
    assign run_op   = (state_q == ST_RUN);
    assign is_rd    = cur.rd_first && !phase_q;
    assign last_op  = (cur.op_cnt == 2'd1) || phase_q;
    assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign mismatch = cmp_vld_q && (mem_do != cmp_exp_q);

    assign ag_load = start_ok || (run_op && last_op && tc && (elem_q != 3'(NUM_ELEM - 1)));
    assign ag_down = !start_ok && elem_is_down(3'(elem_q + 3'd1));
    assign ag_step = run_op && last_op && !tc;

    sram_mbist_addr_gen #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk_i  (CK),
        .rst_i  (RST),
        .load_i (ag_load),
        .down_i (ag_down),
        .step_i (ag_step),
        .addr_o (addr),
        .tc_o   (tc)
    );

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            elem_q      <= '0;
            phase_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            cmp_vld_q   <= 1'b0;
            cmp_exp_q   <= '0;
            cmp_addr_q  <= '0;
            cmp_elem_q  <= '0;
        end else begin
            cmp_vld_q  <= run_op && is_rd;
            cmp_exp_q  <= cur.rd_bg;
            cmp_addr_q <= addr;
            cmp_elem_q <= elem_q;
            if (mismatch) begin
                // First failure wins; a read issued in this same cycle is discarded
                state_q     <= ST_DONE;
                busy_q      <= 1'b0;
                done_q      <= 1'b1;
                fail_q      <= 1'b1;
                fail_addr_q <= cmp_addr_q;
                fail_elem_q <= cmp_elem_q;
                cmp_vld_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            state_q     <= ST_RUN;
                            busy_q      <= 1'b1;
                            done_q      <= 1'b0;
                            fail_q      <= 1'b0;
                            fail_addr_q <= '0;
                            fail_elem_q <= '0;
                            elem_q      <= '0;
                            phase_q     <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (last_op) begin
                            phase_q <= 1'b0;
                            if (tc) begin
                                if (elem_q == 3'(NUM_ELEM - 1)) begin
                                    state_q <= ST_DRAIN;
                                end else begin
                                    elem_q <= 3'(elem_q + 3'd1);
                                end
                            end
                        end else begin
                            phase_q <= 1'b1;
                        end
                    end
                    ST_DRAIN: begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign mem_csb = busy_q ? 1'b0 : func_csb;
    assign mem_oeb = busy_q ? 1'b0 : func_oeb;
    assign mem_web = busy_q ? is_rd : func_web;
    assign mem_a   = busy_q ? addr : func_a;
    assign mem_di  = busy_q ? cur.wr_bg : func_di;

    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_elem = fail_elem_q;

endmodule

// File: tb/tb_sram_mbist.sv
// tb/tb_sram_mbist.sv - self-checking bench for sram_mbist with behavioural macro and March model
module tb_sram_mbist;

    localparam int DEPTH   = 1536;
    localparam int STUCK_A = 5;
    localparam int HOLD_A  = 1535;
    localparam int NOPS    = 10 * DEPTH;

    localparam logic [5:0] E_DOWN = 6'b011000;
    localparam logic [5:0] E_RD   = 6'b111110;
    localparam logic [5:0] E_WR   = 6'b011111;
    localparam logic [5:0] E_RBG  = 6'b010100;
    localparam logic [5:0] E_WBG  = 6'b001010;

    logic        CK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic        func_csb = 1'b1, func_web = 1'b1, func_oeb = 1'b1;
    logic [10:0] func_a = '0;
    logic [7:0]  func_di = '0;
    logic        mem_csb, mem_web, mem_oeb;
    logic [10:0] mem_a;
    logic [7:0]  mem_di;
    logic [7:0]  mem_do = '0;
    logic        busy, done, fail;
    logic [10:0] fail_addr;
    logic [2:0]  fail_elem;

    int n_vec = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;
    logic stuck_en = 1'b0;
    logic hold_en = 1'b0;

    sram_mbist dut (
        .CK(CK), .RST(RST), .start(start),
        .func_csb(func_csb), .func_web(func_web), .func_oeb(func_oeb),
        .func_a(func_a), .func_di(func_di),
        .mem_csb(mem_csb), .mem_web(mem_web), .mem_oeb(mem_oeb),
        .mem_a(mem_a), .mem_di(mem_di), .mem_do(mem_do),
        .busy(busy), .done(done), .fail(fail),
        .fail_addr(fail_addr), .fail_elem(fail_elem)
    );

    always #5 CK = ~CK;

    logic [7:0] mem [0:DEPTH-1];

    always @(posedge CK) begin
        if (!mem_csb && int'(mem_a) < DEPTH) begin
            if (!mem_web) begin
                mem[mem_a] <= (hold_en && int'(mem_a) == HOLD_A) ? 8'h00 : mem_di;
                mem_do     <= mem_di;
            end else begin
                mem_do <= mem[mem_a] | ((stuck_en && int'(mem_a) == STUCK_A) ? 8'h08 : 8'h00);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Walks the March C- sequence over a model array, returning the busy length and first failure
    task automatic predict(input logic st, input logic hd, output int len, output logic pf,
                           output logic [10:0] pa, output logic [2:0] pe);
        logic [7:0] pm [DEPTH];
        logic [7:0] v;
        int off, a;
        off = 0; pf = 1'b0; pa = '0; pe = '0; len = 0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < DEPTH; i++) begin
                a = E_DOWN[e] ? DEPTH - 1 - i : i;
                if (E_RD[e]) begin
                    off++;
                    v = pm[a] | ((st && a == STUCK_A) ? 8'h08 : 8'h00);
                    if (v != (E_RBG[e] ? 8'hFF : 8'h00)) begin
                        len = off + 1; pf = 1'b1; pa = 11'(a); pe = 3'(e);
                        return;
                    end
                end
                if (E_WR[e]) begin
                    off++;
                    pm[a] = (hd && a == HOLD_A) ? 8'h00 : (E_WBG[e] ? 8'hFF : 8'h00);
                end
            end
        end
        len = off + 1;
    endtask

    // Operation issued during the given 1-based cycle of a run
    task automatic op_at(input int off, output int e, output logic [10:0] a, output logic wr);
        int t, u, w, idx;
        t = off - 1;
        if (t < DEPTH) begin
            e = 0; a = 11'(t); wr = 1'b1;
        end else if (t < 9 * DEPTH) begin
            u = t - DEPTH; e = 1 + u / (2 * DEPTH); w = u % (2 * DEPTH); idx = w / 2;
            wr = (w % 2) == 1;
            a = 11'(E_DOWN[e] ? DEPTH - 1 - idx : idx);
        end else begin
            e = 5; a = 11'(t - 9 * DEPTH); wr = 1'b0;
        end
    endtask

    logic        m_running = 1'b0, m_done = 1'b0, m_fail = 1'b0;
    logic [10:0] m_faddr = '0;
    logic [2:0]  m_felem = '0;
    int          m_off = 0;
    int          p_len;
    logic        p_fail;
    logic [10:0] p_addr;
    logic [2:0]  p_elem;

    always @(posedge CK or posedge RST) begin
        if (RST) begin
            m_running = 1'b0; m_done = 1'b0; m_fail = 1'b0; m_faddr = '0; m_felem = '0; m_off = 0;
        end else if (m_running) begin
            if (m_off == p_len) begin
                m_running = 1'b0; m_done = 1'b1; m_fail = p_fail; m_faddr = p_addr; m_felem = p_elem;
            end else begin
                m_off++;
            end
        end else if (start) begin
            predict(stuck_en, hold_en, p_len, p_fail, p_addr, p_elem);
            m_running = 1'b1; m_off = 1; m_done = 1'b0; m_fail = 1'b0; m_faddr = '0; m_felem = '0;
        end
    end

    always @(negedge CK) begin
        int          e;
        logic [10:0] a;
        logic        wr;
        if (chk_en && !RST) begin
            chk("status", {busy, done, fail, fail_addr, fail_elem},
                {m_running, m_done, m_fail, m_faddr, m_felem});
            if (!m_running) begin
                chk("bypass", {mem_csb, mem_web, mem_oeb, mem_a, mem_di},
                    {func_csb, func_web, func_oeb, func_a, func_di});
            end else if (m_off <= NOPS) begin
                op_at(m_off, e, a, wr);
                chk("pins", {mem_csb, mem_oeb, mem_web, mem_a}, {1'b0, 1'b0, !wr, a});
                if (wr) chk("wdata", mem_di, E_WBG[e] ? 8'hFF : 8'h00);
            end
        end
    end

    task automatic run_test(input int dup_at, output int n, output logic fail0);
        @(posedge CK); #1 start = 1'b1;
        @(posedge CK); #1 start = 1'b0;
        n = 0; fail0 = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            @(negedge CK);
            if (i == 0) fail0 = fail;
            if (!busy) break;
            n++;
            @(posedge CK); #1 start = (i == dup_at);
        end
        start = 1'b0;
    endtask

    function automatic int nonzero_words();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== 8'h00) c++;
        return c;
    endfunction

    int   n;
    logic f0;

    initial begin
        repeat (3) @(posedge CK);
        #1;
        chk("reset_status", {busy, done, fail, fail_addr, fail_elem}, 17'h0);
        chk("reset_bypass", {mem_csb, mem_web, mem_oeb, mem_a, mem_di}, {3'b111, 11'h0, 8'h0});
        RST = 1'b0;
        chk_en = 1'b1;

        @(posedge CK); #1;
        func_a = 11'h2AB; func_di = 8'h5A; func_web = 1'b0; func_csb = 1'b0; func_oeb = 1'b1;
        #1;
        chk("idle_a", mem_a, 11'h2AB);
        chk("idle_di", mem_di, 8'h5A);
        chk("idle_ctl", {mem_csb, mem_web, mem_oeb}, 3'b001);
        @(posedge CK); #1;
        func_csb = 1'b1; func_web = 1'b1;

        run_test(5000, n, f0);
        chk("clean_len", n, 15361);
        chk("clean_result", {done, fail}, 2'b10);
        chk("clean_mem", nonzero_words(), 0);

        stuck_en = 1'b1;
        run_test(-1, n, f0);
        chk("stuck_len", n, 1548);
        chk("stuck_result", {done, fail, fail_addr, fail_elem}, {2'b11, 11'd5, 3'd1});

        stuck_en = 1'b0;
        run_test(-1, n, f0);
        chk("restart_fail_clear", f0, 1'b0);
        chk("restart_len", n, 15361);
        chk("restart_result", {done, fail}, 2'b10);
        chk("restart_mem", nonzero_words(), 0);

        hold_en = 1'b1;
        run_test(-1, n, f0);
        chk("hold_len", n, 7680);
        chk("hold_result", {done, fail, fail_addr, fail_elem}, {2'b11, 11'd1535, 3'd2});
        hold_en = 1'b0;

        func_a = 11'h123; func_di = 8'hC3; func_csb = 1'b1; func_web = 1'b1; func_oeb = 1'b0;
        @(posedge CK); #1 start = 1'b1;
        @(posedge CK); #1 start = 1'b0;
        repeat (7000) @(posedge CK);
        #2 RST = 1'b1;
        #1;
        chk("rst_status", {busy, done, fail}, 3'b000);
        chk("rst_bypass", {mem_csb, mem_web, mem_oeb, mem_a, mem_di}, {3'b110, 11'h123, 8'hC3});
        @(posedge CK); #1 RST = 1'b0;
        repeat (20) @(posedge CK);
        #1;
        chk("post_rst_idle", {busy, done, fail}, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
